// File: rtl/alu_seq_param.sv
// Multi-cycle unsigned ALU: single-cycle ADD/SUB/CMP, iterative shift-add MUL and
// restoring DIV, valid/ready on both sides with results held until accepted.
module alu_seq_param #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] rs,
   input  logic [WIDTH-1:0] rt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_hi,
   output logic [2:0]       nzp,
   output logic             carry,
   output logic             div_by_zero,
   output logic             illegal_op
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_CMP = 3'b100;

   state_t           state, state_next;
   logic             accept;
   logic             iterative;
   logic             is_div;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] work_hi, work_lo;

   logic             step_div;
   logic [WIDTH-1:0] src_hi, src_lo, src_b;
   logic [WIDTH-1:0] step_hi, step_lo;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH-1:0] div_diff;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign iterative = (op == OP_MUL) || ((op == OP_DIV) && (rt != '0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = iterative ? BUSY : DONE;
         BUSY:    if (cnt == CNT_W'(1)) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The acceptance edge performs the first iteration straight from the live operands,
   // so WIDTH iterations complete exactly WIDTH cycles after acceptance.
   always_comb begin
      if (state == IDLE) begin
         src_hi   = '0;
         src_lo   = rs;
         src_b    = rt;
         step_div = (op == OP_DIV);
      end else begin
         src_hi   = work_hi;
         src_lo   = work_lo;
         src_b    = b_q;
         step_div = is_div;
      end
   end

   // MUL: {hi,lo} holds {partial product, remaining multiplier bits}.
   // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   always_comb begin
      mul_sum   = {1'b0, src_hi} + (src_lo[0] ? {1'b0, src_b} : '0);
      div_shift = {src_hi, src_lo[WIDTH-1]};
      div_diff  = div_shift[WIDTH-1:0] - src_b;
      step_hi   = '0;
      step_lo   = '0;
      if (step_div) begin
         if (div_shift >= {1'b0, src_b}) begin
            step_hi = div_diff;
            step_lo = {src_lo[WIDTH-2:0], 1'b1};
         end else begin
            step_hi = div_shift[WIDTH-1:0];
            step_lo = {src_lo[WIDTH-2:0], 1'b0};
         end
      end else begin
         {step_hi, step_lo} = {mul_sum, src_lo[WIDTH-1:1]};
      end
   end

   // NOTE: the working registers are reset along with the outputs so an aborted
   // operation leaves nothing behind that could be mistaken for a partial result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         is_div      <= 1'b0;
         b_q         <= '0;
         work_hi     <= '0;
         work_lo     <= '0;
         cnt         <= '0;
         result      <= '0;
         result_hi   <= '0;
         nzp         <= '0;
         carry       <= 1'b0;
         div_by_zero <= 1'b0;
         illegal_op  <= 1'b0;
      end else if (accept) begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values, regardless of statement order.
         is_div  <= (op == OP_DIV);
         b_q     <= rt;
         work_hi <= step_hi;
         work_lo <= step_lo;
         cnt     <= CNT_W'(WIDTH - 1);
         if (!iterative) begin
            result      <= '0;
            result_hi   <= '0;
            nzp         <= '0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
            case (op)
               OP_ADD: {carry, result} <= {1'b0, rs} + {1'b0, rt};
               OP_SUB: begin
                  result <= rs - rt;
                  carry  <= (rs < rt);
               end
               OP_DIV: begin
                  result      <= '1;
                  result_hi   <= rs;
                  div_by_zero <= 1'b1;
               end
               OP_CMP:                    nzp <= {rs > rt, rs == rt, rs < rt};
               3'b101, 3'b110, 3'b111:    illegal_op <= 1'b1;
               default: ;
            endcase
         end
      end else if (state == BUSY) begin
         work_hi <= step_hi;
         work_lo <= step_lo;
         cnt     <= cnt - CNT_W'(1);
         if (cnt == CNT_W'(1)) begin
            result      <= step_lo;
            result_hi   <= step_hi;
            nzp         <= '0;
            carry       <= 1'b0;
            div_by_zero <= 1'b0;
            illegal_op  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_seq_param.sv
// Self-checking bench for alu_seq_param: directed and random operations against an
// arithmetic reference model, with backpressure, latency, mid-operation reset and a 16-bit MUL.
module tb_alu_seq_param;

   localparam int W = 8;
   localparam int M = 1 << W;

   typedef struct {
      int res;
      int hi;
      int nzp;
      int carry;
      int dbz;
      int ill;
      int lat;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    op = '0;
   logic [W-1:0]  rs = '0;
   logic [W-1:0]  rt = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  result;
   logic [W-1:0]  result_hi;
   logic [2:0]    nzp;
   logic          carry;
   logic          div_by_zero;
   logic          illegal_op;

   logic          iv_w = 1'b0;
   logic          ir_w;
   logic [2:0]    op_w = '0;
   logic [15:0]   rs_w = '0;
   logic [15:0]   rt_w = '0;
   logic          ov_w;
   logic          or_w = 1'b0;
   logic [15:0]   res_w;
   logic [15:0]   hi_w;
   logic [2:0]    nzp_w;
   logic          carry_w;
   logic          dbz_w;
   logic          ill_w;

   int n_cmp = 0;
   int n_err = 0;

   alu_seq_param #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .op(op), .rs(rs), .rt(rt),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .result_hi(result_hi), .nzp(nzp), .carry(carry),
      .div_by_zero(div_by_zero), .illegal_op(illegal_op)
   );

   alu_seq_param #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset),
      .in_valid(iv_w), .in_ready(ir_w), .op(op_w), .rs(rs_w), .rt(rt_w),
      .out_valid(ov_w), .out_ready(or_w),
      .result(res_w), .result_hi(hi_w), .nzp(nzp_w), .carry(carry_w),
      .div_by_zero(dbz_w), .illegal_op(ill_w)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic exp_t model(input int o, input int a, input int b);
      exp_t e;
      e = '{default: 0};
      e.lat = 1;
      case (o)
         0: begin e.res = (a + b) % M; e.carry = (a + b) / M; end
         1: begin e.res = (a - b + M) % M; e.carry = (a < b) ? 1 : 0; end
         2: begin e.res = (a * b) % M; e.hi = (a * b) / M; e.lat = W; end
         3: if (b == 0) begin
               e.res = M - 1; e.hi = a; e.dbz = 1;
            end else begin
               e.res = a / b; e.hi = a % b; e.lat = W;
            end
         4: e.nzp = (a > b) ? 4 : (a == b) ? 2 : 1;
         default: e.ill = 1;
      endcase
      return e;
   endfunction

   task automatic run_op(input string tag, input int o, input int a, input int b, input int hold);
      exp_t e;
      int lat;
      logic [21:0] snap;
      e = model(o, a, b);
      @(negedge clk);
      check({tag, ".in_ready_idle"}, in_ready, 1);
      in_valid = 1'b1;
      op = 3'(o);
      rs = W'(a);
      rt = W'(b);
      @(posedge clk);
      lat = 0;
      while (lat < 40) begin
         @(negedge clk);
         lat++;
         if (out_valid) break;
         check({tag, ".in_ready_busy"}, in_ready, 0);
         in_valid  = 1'($urandom);
         op        = 3'($urandom);
         rs        = W'($urandom);
         rt        = W'($urandom);
         out_ready = 1'($urandom);
      end
      out_ready = 1'b0;
      check({tag, ".latency"}, lat, e.lat);
      check({tag, ".result"}, result, e.res);
      check({tag, ".result_hi"}, result_hi, e.hi);
      check({tag, ".nzp"}, nzp, e.nzp);
      check({tag, ".carry"}, carry, e.carry);
      check({tag, ".div_by_zero"}, div_by_zero, e.dbz);
      check({tag, ".illegal_op"}, illegal_op, e.ill);
      snap = {result, result_hi, nzp, carry, div_by_zero, illegal_op};
      repeat (hold) begin
         in_valid = 1'($urandom);
         op       = 3'($urandom);
         rs       = W'($urandom);
         rt       = W'($urandom);
         @(negedge clk);
         check({tag, ".hold_in_ready"}, in_ready, 0);
         check({tag, ".hold_out_valid"}, out_valid, 1);
         check({tag, ".hold_stable"}, {result, result_hi, nzp, carry, div_by_zero, illegal_op}, snap);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, ".drain_out_valid"}, out_valid, 0);
      check({tag, ".drain_in_ready"}, in_ready, 1);
   endtask

   initial begin
      int seen;
      int lat;
      int o, a, b;

      #1 reset = 1'b0;
      #1;
      check("reset.in_ready", in_ready, 1);
      check("reset.out_valid", out_valid, 0);
      check("reset.outputs", {result, result_hi, nzp, carry, div_by_zero, illegal_op}, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      run_op("add_200_100", 0, 200, 100, 1);
      run_op("sub_5_9", 1, 5, 9, 2);
      run_op("cmp_9_9", 4, 9, 9, 0);
      run_op("cmp_3_9", 4, 3, 9, 0);
      run_op("cmp_9_3", 4, 9, 3, 0);
      run_op("mul_255_255", 2, 255, 255, 5);
      run_op("div_100_7", 3, 100, 7, 1);
      run_op("div_37_0", 3, 37, 0, 1);

      // Abort a DIV mid-iteration with an asynchronous reset.
      @(negedge clk);
      in_valid = 1'b1; op = 3'd3; rs = 8'd100; rt = 8'd7;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("abort.busy", out_valid, 0);
      #2 reset = 1'b0;
      #1;
      check("abort.outputs", {result, result_hi, nzp, carry, div_by_zero, illegal_op}, 0);
      check("abort.out_valid", out_valid, 0);
      check("abort.in_ready", in_ready, 1);
      @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("abort.no_result", seen, 0);
      check("abort.in_ready_after", in_ready, 1);

      run_op("illegal_110", 6, 17, 42, 0);

      for (int i = 0; i < 40; i++) begin
         o = $urandom_range(0, 7);
         case ($urandom_range(0, 3))
            0:       a = 0;
            1:       a = M - 1;
            default: a = $urandom_range(0, M - 1);
         endcase
         case ($urandom_range(0, 4))
            0:       b = 0;
            1:       b = 1;
            2:       b = M - 1;
            default: b = $urandom_range(0, M - 1);
         endcase
         run_op($sformatf("rand%0d_op%0d", i, o), o, a, b, $urandom_range(0, 3));
      end

      // 16-bit instance: full-range multiply.
      @(negedge clk);
      iv_w = 1'b1; op_w = 3'd2; rs_w = 16'hFFFF; rt_w = 16'hFFFF;
      @(posedge clk);
      lat = 0;
      while (lat < 60) begin
         @(negedge clk);
         lat++;
         iv_w = 1'b0;
         if (ov_w) break;
      end
      check("mul16.latency", lat, 16);
      check("mul16.result", res_w, 16'h0001);
      check("mul16.result_hi", hi_w, 16'hFFFE);
      check("mul16.flags", {nzp_w, carry_w, dbz_w, ill_w}, 0);
      or_w = 1'b1;
      @(negedge clk);
      or_w = 1'b0;
      check("mul16.drain", {ov_w, ir_w}, 2'b01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
